// File: rtl/store_buffer.sv
// RV32I store formatting (SB/SH/SW) with alignment checks, feeding a small FIFO
// that drains formatted writes to data memory over a req/ack handshake.
module store_buffer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 32,
    localparam int unsigned CW   = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          st_valid,
    output logic          st_ready,
    input  logic [AW-1:0] st_addr,
    input  logic [31:0]   st_data,
    input  logic [2:0]    st_funct3,
    output logic          st_err,
    output logic [AW-1:0] st_err_addr,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    output logic [3:0]    mem_be,
    input  logic          mem_ack,
    output logic          empty,
    output logic [CW-1:0] count
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [AW-1:0] addr_mem  [DEPTH];
    logic [31:0]   wdata_mem [DEPTH];
    logic [3:0]    be_mem    [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ready_q, ready_d;
    logic          err_q, err_d;
    logic [AW-1:0] err_addr_q, err_addr_d;

    logic          fmt_ok;
    logic [3:0]    fmt_be;
    logic [31:0]   fmt_wdata;
    logic          accept, push, pop;

    always_comb begin
        fmt_ok    = 1'b0;
        fmt_be    = 4'b0000;
        fmt_wdata = 32'h0;
        case (st_funct3)
            3'b000: begin
                fmt_ok    = 1'b1;
                fmt_be    = 4'b0001 << st_addr[1:0];
                fmt_wdata = {4{st_data[7:0]}};
            end
            3'b001: begin
                fmt_ok    = ~st_addr[0];
                fmt_be    = st_addr[1] ? 4'b1100 : 4'b0011;
                fmt_wdata = {2{st_data[15:0]}};
            end
            3'b010: begin
                fmt_ok    = (st_addr[1:0] == 2'b00);
                fmt_be    = 4'b1111;
                fmt_wdata = st_data;
            end
            default: ;
        endcase
    end

    assign accept = st_valid && ready_q;
    assign push   = accept && fmt_ok;
    assign pop    = mem_req && mem_ack;

    always_comb begin
        wr_ptr_d   = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d    = count_q + CW'(push) - CW'(pop);
        // Registered so a same-cycle pop cannot reopen acceptance combinationally.
        ready_d    = (count_d != CW'(DEPTH));
        err_d      = accept && !fmt_ok;
        err_addr_d = err_d ? st_addr : err_addr_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ready_q    <= 1'b1;
            err_q      <= 1'b0;
            err_addr_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ready_q    <= ready_d;
            err_q      <= err_d;
            err_addr_q <= err_addr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr_q]  <= {st_addr[AW-1:2], 2'b00};
            wdata_mem[wr_ptr_q] <= fmt_wdata;
            be_mem[wr_ptr_q]    <= fmt_be;
        end
    end

    assign st_ready    = ready_q;
    assign st_err      = err_q;
    assign st_err_addr = err_addr_q;
    assign count       = count_q;
    assign empty       = (count_q == '0);
    assign mem_req     = !empty;
    assign mem_addr    = addr_mem[rd_ptr_q];
    assign mem_wdata   = wdata_mem[rd_ptr_q];
    assign mem_be      = be_mem[rd_ptr_q];

endmodule

// File: tb/tb_store_buffer.sv
// Directed plus randomized bench for store_buffer, checked against a queue-based
// model of the buffered writes.
module tb_store_buffer;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned AW    = 32;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          st_valid;
    logic          st_ready;
    logic [AW-1:0] st_addr;
    logic [31:0]   st_data;
    logic [2:0]    st_funct3;
    logic          st_err;
    logic [AW-1:0] st_err_addr;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [3:0]    mem_be;
    logic          mem_ack;
    logic          empty;
    logic [CW-1:0] count;

    store_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk         (clk),
        .rst         (rst),
        .st_valid    (st_valid),
        .st_ready    (st_ready),
        .st_addr     (st_addr),
        .st_data     (st_data),
        .st_funct3   (st_funct3),
        .st_err      (st_err),
        .st_err_addr (st_err_addr),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_be      (mem_be),
        .mem_ack     (mem_ack),
        .empty       (empty),
        .count       (count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } ent_t;

    ent_t        mq[$];
    logic        m_ready;
    logic        m_err;
    logic [31:0] m_err_addr;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_ready    = 1'b1;
        m_err      = 1'b0;
        m_err_addr = 32'h0;
    endtask

    // Evaluates one clock edge from the store rules, using the inputs driven for it.
    task automatic model_edge();
        bit          legal;
        int unsigned off;
        ent_t        e;
        bit          acc;
        off   = int'(st_addr[1:0]);
        legal = 1'b0;
        e.addr  = st_addr & 32'hFFFF_FFFC;
        e.be    = 4'h0;
        e.wdata = 32'h0;
        if (st_funct3 == 3'd0) begin
            legal   = 1'b1;
            e.be    = 4'(1 << off);
            e.wdata = 32'(st_data[7:0]) * 32'h0101_0101;
        end else if (st_funct3 == 3'd1) begin
            legal   = (off % 2) == 0;
            e.be    = 4'(3 << off);
            e.wdata = 32'(st_data[15:0]) * 32'h0001_0001;
        end else if (st_funct3 == 3'd2) begin
            legal   = (off == 0);
            e.be    = 4'hF;
            e.wdata = st_data;
        end
        acc = st_valid && m_ready;
        if (mem_ack && mq.size() != 0) void'(mq.pop_front());
        if (acc && legal) mq.push_back(e);
        m_err = acc && !legal;
        if (m_err) m_err_addr = st_addr;
        m_ready = (mq.size() != DEPTH);
    endtask

    task automatic check_all();
        check_eq("count", 32'(count), 32'(mq.size()));
        check_eq("empty", 32'(empty), 32'(mq.size() == 0));
        check_eq("mem_req", 32'(mem_req), 32'(mq.size() != 0));
        check_eq("st_ready", 32'(st_ready), 32'(m_ready));
        check_eq("st_err", 32'(st_err), 32'(m_err));
        check_eq("st_err_addr", st_err_addr, m_err_addr);
        if (mq.size() != 0) begin
            check_eq("mem_addr", mem_addr, mq[0].addr);
            check_eq("mem_be", 32'(mem_be), 32'(mq[0].be));
            check_eq("mem_wdata", mem_wdata, mq[0].wdata);
        end
    endtask

    // Called at a negedge: drive, take one edge, check at the following negedge.
    task automatic step(input logic v, input logic [31:0] a, input logic [31:0] d,
                        input logic [2:0] f, input logic ack);
        st_valid  = v;
        st_addr   = a;
        st_data   = d;
        st_funct3 = f;
        mem_ack   = ack;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    initial begin
        rst       = 1'b1;
        st_valid  = 1'b0;
        st_addr   = 32'h0;
        st_data   = 32'h0;
        st_funct3 = 3'b000;
        mem_ack   = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all();
        rst = 1'b0;

        step(1'b1, 32'h100, 32'hDEAD_BEEF, 3'b010, 1'b0);
        check_eq("sw_req", 32'(mem_req), 32'd1);
        check_eq("sw_wdata", mem_wdata, 32'hDEAD_BEEF);
        check_eq("sw_be", 32'(mem_be), 32'hF);
        step(1'b0, 32'h0, 32'h0, 3'b000, 1'b1);
        check_eq("sw_drained", 32'(empty), 32'd1);

        step(1'b1, 32'h203, 32'h0000_00A5, 3'b000, 1'b0);
        check_eq("sb_be", 32'(mem_be), 32'h8);
        check_eq("sb_wdata", mem_wdata, 32'hA5A5_A5A5);
        step(1'b1, 32'h202, 32'h0000_1234, 3'b001, 1'b1);
        step(1'b0, 32'h0, 32'h0, 3'b000, 1'b0);
        check_eq("sh_wdata", mem_wdata, 32'h1234_1234);
        step(1'b0, 32'h0, 32'h0, 3'b000, 1'b1);

        step(1'b1, 32'h301, 32'h1, 3'b001, 1'b0);
        check_eq("sh_mis_err", 32'(st_err), 32'd1);
        step(1'b1, 32'h302, 32'h2, 3'b010, 1'b0);
        check_eq("sw_mis_addr", st_err_addr, 32'h302);
        step(1'b1, 32'h304, 32'h3, 3'b011, 1'b0);
        step(1'b0, 32'h0, 32'h0, 3'b000, 1'b0);
        check_eq("err_pulse_end", 32'(st_err), 32'd0);

        for (int i = 1; i <= 5; i++)
            step(1'b1, 32'h400 + 32'(4 * i), 32'(i) * 32'h1111_1111, 3'b010, 1'b0);
        check_eq("full_count", 32'(count), 32'd4);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 32'h0, 32'h0, 3'b000, 1'b0);
            step(1'b0, 32'h0, 32'h0, 3'b000, 1'b1);
        end

        for (int i = 0; i < 4; i++)
            step(1'b1, 32'h500 + 32'(4 * i), 32'h5000 + 32'(i), 3'b010, 1'b0);
        step(1'b1, 32'h600, 32'h6666_6666, 3'b010, 1'b1);
        check_eq("full_pop_count", 32'(count), 32'd3);
        step(1'b1, 32'h604, 32'h7777_7777, 3'b010, 1'b0);
        check_eq("refill_count", 32'(count), 32'd4);
        repeat (4) step(1'b0, 32'h0, 32'h0, 3'b000, 1'b1);

        step(1'b1, 32'h700, 32'hAAAA_0001, 3'b010, 1'b0);
        step(1'b1, 32'h704, 32'hAAAA_0002, 3'b010, 1'b0);
        #2 rst = 1'b1;
        mem_ack = 1'b1;
        #1;
        check_eq("rst_req", 32'(mem_req), 32'd0);
        check_eq("rst_count", 32'(count), 32'd0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_all();
        step(1'b1, 32'h800, 32'hCAFE_F00D, 3'b010, 1'b0);
        step(1'b0, 32'h0, 32'h0, 3'b000, 1'b1);

        for (int i = 0; i < 400; i++) begin
            logic [2:0] f;
            f = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(3, 7));
            step(1'($urandom_range(0, 9) < 6), $urandom(), $urandom(), f,
                 1'($urandom_range(0, 9) < 4));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
